// File: rtl/ram_scanout_reader.sv
// Streams a width x height frame out of a synchronous RAM as a pixel stream.
// A 4-entry FIFO with credit-based issue absorbs the one-cycle RAM latency under backpressure.
module ram_scanout_reader #(
  parameter int addrSize = 7,
  parameter int depth    = 8,
  parameter int width    = 16,
  parameter int height   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr_read,
  input  logic [depth-1:0]    ram_data,
  output logic [depth-1:0]    pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                pix_eof
);
  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam int RW = (height > 1) ? $clog2(height) : 1;
  localparam int EW = depth + 3;
  localparam logic [addrSize-1:0] ADDR_LAST = addrSize'(width * height - 1);
  localparam logic [CW-1:0]       COL_LAST  = CW'(width - 1);
  localparam logic [RW-1:0]       ROW_LAST  = RW'(height - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q;
  logic [addrSize-1:0] addr_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [1:0]          inflight_q, inflight_d;
  logic [2:0]          tag_q;
  logic [EW-1:0]       mem_q [4];
  logic [1:0]          wr_q, rd_q;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          occ;
  logic                issue, push, pop, flush_done;
  logic [EW-1:0]       head;

  // A read is only issued when it is sure to find a FIFO slot, counting the one in flight.
  always_comb begin
    occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
    issue      = (state_q == RUN) && (occ < 4'd4);
    push       = (inflight_q != 2'd0);
    pop        = pix_valid && pix_ready;
    flush_done = (state_q == FLUSH) && (cnt_q == 3'd0) && (inflight_q == 2'd0);
    cnt_d      = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + 2'd1;
    else if (!issue && push) inflight_d = inflight_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 2'd0;
      tag_q      <= 3'b000;
      wr_q       <= 2'd0;
      rd_q       <= 2'd0;
      cnt_q      <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          addr_q  <= '0;
          col_q   <= '0;
          row_q   <= '0;
        end
        RUN: if (issue) begin
          tag_q <= {addr_q == ADDR_LAST, col_q == COL_LAST, addr_q == '0};
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
          // Wrap to 0 after the last pixel so the address never leaves the frame.
          if (addr_q == ADDR_LAST) begin
            addr_q  <= '0;
            state_q <= FLUSH;
          end else begin
            addr_q <= addr_q + addrSize'(1);
          end
        end
        FLUSH: if (flush_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (push) begin
        mem_q[wr_q] <= {tag_q, ram_data};
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign head          = mem_q[rd_q];
  assign pix_valid     = (cnt_q != 3'd0);
  assign pix_data      = head[depth-1:0];
  assign pix_sof       = pix_valid & head[depth];
  assign pix_eol       = pix_valid & head[depth+1];
  assign pix_eof       = pix_valid & head[depth+2];
  assign busy          = (state_q != IDLE);
  assign done          = flush_done;
  assign ram_enable    = reset;
  assign ram_addr_read = addr_q;
endmodule
